// File: rtl/fp_cal_norm_skid.sv
// cal->norm FP-adder pipeline register with a 2-entry skid buffer; 1-cycle latency when M is free or popping.
// Backpressure: in_ready comes from registered skid state only, so out_ready never reaches it combinationally.
module fp_cal_norm_skid #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int CAL_W = MAN_W + 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       c_rm,
  input  logic             c_is_nan,
  input  logic             c_is_inf,
  input  logic [MAN_W-1:0] c_inf_nan_frac,
  input  logic             c_sign,
  input  logic [EXP_W-1:0] c_exp,
  input  logic [CAL_W-1:0] c_frac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       n_rm,
  output logic             n_is_nan,
  output logic             n_is_inf,
  output logic [MAN_W-1:0] n_inf_nan_frac,
  output logic             n_sign,
  output logic [EXP_W-1:0] n_exp,
  output logic [CAL_W-1:0] n_frac,
  output logic [1:0]       count
);

  typedef struct packed {
    logic [1:0]       rm;
    logic             is_nan;
    logic             is_inf;
    logic [MAN_W-1:0] inf_nan_frac;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [CAL_W-1:0] frac;
  } bundle_t;

  bundle_t in_bundle;
  bundle_t m_dat;
  bundle_t s_dat;
  logic    m_valid;
  logic    s_valid;
  logic    acc;
  logic    pop;

  assign in_bundle = '{rm: c_rm, is_nan: c_is_nan, is_inf: c_is_inf,
                       inf_nan_frac: c_inf_nan_frac, sign: c_sign,
                       exp: c_exp, frac: c_frac};

  assign in_ready  = ~s_valid & ~clr;
  assign out_valid = m_valid;
  assign count     = {1'b0, m_valid} + {1'b0, s_valid};
  assign acc       = in_valid & in_ready;
  assign pop       = m_valid & out_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_dat   <= '0;
      s_dat   <= '0;
    end else if (flush) begin
      // Only the valid bits drop; data is left as-is since nothing downstream looks at it.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (pop) begin
      if (s_valid) begin
        m_dat   <= s_dat;
        s_valid <= 1'b0;
      end else if (acc) begin
        m_dat   <= in_bundle;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (!m_valid) begin
      if (acc) begin
        m_dat   <= in_bundle;
        m_valid <= 1'b1;
      end
    end else if (acc) begin
      s_dat   <= in_bundle;
      s_valid <= 1'b1;
    end
  end

  assign n_rm           = m_dat.rm;
  assign n_is_nan       = m_dat.is_nan;
  assign n_is_inf       = m_dat.is_inf;
  assign n_inf_nan_frac = m_dat.inf_nan_frac;
  assign n_sign         = m_dat.sign;
  assign n_exp          = m_dat.exp;
  assign n_frac         = m_dat.frac;

endmodule

// File: tb/tb_fp_cal_norm_skid.sv
// Directed bench for fp_cal_norm_skid at half (5/10) and single (8/23) precision widths.
module tb_fp_cal_norm_skid;

  logic clk = 1'b0;
  logic clr;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // half-precision instance
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [1:0]  h_c_rm, h_n_rm, h_count;
  logic        h_c_is_nan, h_c_is_inf, h_c_sign, h_n_is_nan, h_n_is_inf, h_n_sign;
  logic [9:0]  h_c_inf_nan_frac, h_n_inf_nan_frac;
  logic [4:0]  h_c_exp, h_n_exp;
  logic [14:0] h_c_frac, h_n_frac;

  // single-precision instance
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [1:0]  w_c_rm, w_n_rm, w_count;
  logic        w_c_is_nan, w_c_is_inf, w_c_sign, w_n_is_nan, w_n_is_inf, w_n_sign;
  logic [22:0] w_c_inf_nan_frac, w_n_inf_nan_frac;
  logic [7:0]  w_c_exp, w_n_exp;
  logic [27:0] w_c_frac, w_n_frac;

  fp_cal_norm_skid #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .c_rm(h_c_rm), .c_is_nan(h_c_is_nan), .c_is_inf(h_c_is_inf),
    .c_inf_nan_frac(h_c_inf_nan_frac), .c_sign(h_c_sign),
    .c_exp(h_c_exp), .c_frac(h_c_frac),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .n_rm(h_n_rm), .n_is_nan(h_n_is_nan), .n_is_inf(h_n_is_inf),
    .n_inf_nan_frac(h_n_inf_nan_frac), .n_sign(h_n_sign),
    .n_exp(h_n_exp), .n_frac(h_n_frac), .count(h_count)
  );

  fp_cal_norm_skid #(.EXP_W(8), .MAN_W(23)) dut_w (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .c_rm(w_c_rm), .c_is_nan(w_c_is_nan), .c_is_inf(w_c_is_inf),
    .c_inf_nan_frac(w_c_inf_nan_frac), .c_sign(w_c_sign),
    .c_exp(w_c_exp), .c_frac(w_c_frac),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .n_rm(w_n_rm), .n_is_nan(w_n_is_nan), .n_is_inf(w_n_is_inf),
    .n_inf_nan_frac(w_n_inf_nan_frac), .n_sign(w_n_sign),
    .n_exp(w_n_exp), .n_frac(w_n_frac), .count(w_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic h_send(input logic [4:0] e, input logic [14:0] f);
    h_in_valid = 1'b1;
    h_c_exp    = e;
    h_c_frac   = f;
  endtask

  task automatic w_send(input logic [7:0] e, input logic [27:0] f);
    w_in_valid = 1'b1;
    w_c_exp    = e;
    w_c_frac   = f;
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0;
    h_in_valid = 1'b1; h_out_ready = 1'b0;
    h_c_rm = 2'b01; h_c_is_nan = 1'b0; h_c_is_inf = 1'b0; h_c_inf_nan_frac = '0;
    h_c_sign = 1'b0; h_c_exp = 5'h1A; h_c_frac = 15'h1234;
    w_in_valid = 1'b1; w_out_ready = 1'b0;
    w_c_rm = 2'b00; w_c_is_nan = 1'b0; w_c_is_inf = 1'b0; w_c_inf_nan_frac = '0;
    w_c_sign = 1'b0; w_c_exp = 8'h00; w_c_frac = '0;

    // reset: two cycles with in_valid held high
    step();
    chk("rst_in_ready_c1", h_in_ready, 0);
    step();
    chk("rst_in_ready_c2", h_in_ready, 0);
    chk("rst_out_valid", h_out_valid, 0);
    chk("rst_count", h_count, 0);
    chk("rst_n_exp", h_n_exp, 0);
    chk("rst_n_frac", h_n_frac, 0);
    chk("rst_w_count", w_count, 0);
    clr = 1'b0; h_in_valid = 1'b0; w_in_valid = 1'b0;
    #1;
    chk("rel_in_ready", h_in_ready, 1);
    chk("rel_out_valid", h_out_valid, 0);

    // streaming: one bundle per clock
    h_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      h_send(5'h0F + 5'(i), 15'h4000 + 15'(i));
      #1;
      chk("strm_in_ready", h_in_ready, 1);
      step();
      chk("strm_out_valid", h_out_valid, 1);
      chk("strm_n_exp", h_n_exp, 64'(5'h0F + 5'(i)));
      chk("strm_n_frac", h_n_frac, 64'(15'h4000 + 15'(i)));
      chk("strm_count", h_count, 1);
    end
    h_in_valid = 1'b0;
    step();
    chk("strm_drain_valid", h_out_valid, 0);
    chk("strm_drain_count", h_count, 0);

    // backpressure: A, B accepted, C held off
    h_out_ready = 1'b0;
    h_send(5'h10, 15'h0A0A);
    step();
    chk("bp_A_count", h_count, 1);
    chk("bp_A_exp", h_n_exp, 64'h10);
    h_send(5'h11, 15'h0B0B);
    step();
    chk("bp_B_count", h_count, 2);
    chk("bp_B_in_ready", h_in_ready, 0);
    h_send(5'h12, 15'h0C0C);
    step();
    chk("bp_C_count", h_count, 2);
    chk("bp_hold_exp", h_n_exp, 64'h10);
    chk("bp_hold_frac", h_n_frac, 64'h0A0A);
    chk("bp_C_in_ready", h_in_ready, 0);
    h_out_ready = 1'b1;
    step();
    chk("bp_pop1_valid", h_out_valid, 1);
    chk("bp_pop1_exp", h_n_exp, 64'h11);
    chk("bp_pop1_count", h_count, 1);
    chk("bp_pop1_in_ready", h_in_ready, 1);
    step();
    chk("bp_pop2_valid", h_out_valid, 1);
    chk("bp_pop2_exp", h_n_exp, 64'h12);
    chk("bp_pop2_frac", h_n_frac, 64'h0C0C);
    chk("bp_pop2_count", h_count, 1);
    h_in_valid = 1'b0;
    step();
    chk("bp_drain_valid", h_out_valid, 0);

    // flush with a full buffer and D presented
    h_out_ready = 1'b0;
    h_send(5'h13, 15'h1313);
    step();
    h_send(5'h14, 15'h1414);
    step();
    chk("fl_pre_count", h_count, 2);
    flush = 1'b1;
    h_send(5'h1F, 15'h7D7D);
    step();
    flush = 1'b0; h_in_valid = 1'b0;
    chk("fl_out_valid", h_out_valid, 0);
    chk("fl_count", h_count, 0);
    chk("fl_in_ready", h_in_ready, 1);
    h_out_ready = 1'b1;
    step();
    chk("fl_no_D_valid", h_out_valid, 0);
    chk("fl_no_D_count", h_count, 0);

    // special NaN bundle
    h_c_rm = 2'b11; h_c_is_nan = 1'b1; h_c_is_inf = 1'b0;
    h_c_inf_nan_frac = 10'h200; h_c_sign = 1'b1;
    h_send(5'h1F, 15'h7FFF);
    step();
    h_in_valid = 1'b0;
    chk("sp_valid", h_out_valid, 1);
    chk("sp_rm", h_n_rm, 3);
    chk("sp_is_nan", h_n_is_nan, 1);
    chk("sp_is_inf", h_n_is_inf, 0);
    chk("sp_inf_nan_frac", h_n_inf_nan_frac, 64'h200);
    chk("sp_sign", h_n_sign, 1);
    chk("sp_exp", h_n_exp, 64'h1F);
    chk("sp_frac", h_n_frac, 64'h7FFF);
    step();

    // single-precision passthrough
    w_out_ready = 1'b1;
    w_c_rm = 2'b10; w_c_is_inf = 1'b1; w_c_sign = 1'b1; w_c_inf_nan_frac = 23'h5A5A5A;
    w_send(8'h7F, 28'hA5A5A5A);
    step();
    w_in_valid = 1'b0;
    chk("w_valid", w_out_valid, 1);
    chk("w_exp", w_n_exp, 64'h7F);
    chk("w_frac", w_n_frac, 64'hA5A5A5A);
    chk("w_inf_nan_frac", w_n_inf_nan_frac, 64'h5A5A5A);
    chk("w_rm", w_n_rm, 2);
    chk("w_is_inf", w_n_is_inf, 1);
    chk("w_sign", w_n_sign, 1);
    step();
    chk("w_drain_valid", w_out_valid, 0);

    // single-precision backpressure
    w_out_ready = 1'b0;
    w_send(8'h80, 28'hFFFFFFF);
    step();
    w_send(8'h81, 28'h0000001);
    step();
    chk("w_bp_count", w_count, 2);
    w_send(8'h82, 28'h8000000);
    step();
    chk("w_bp_hold_exp", w_n_exp, 64'h80);
    chk("w_bp_hold_frac", w_n_frac, 64'hFFFFFFF);
    chk("w_bp_in_ready", w_in_ready, 0);
    w_out_ready = 1'b1;
    step();
    chk("w_bp_pop1_exp", w_n_exp, 64'h81);
    chk("w_bp_pop1_valid", w_out_valid, 1);
    step();
    w_in_valid = 1'b0;
    chk("w_bp_pop2_exp", w_n_exp, 64'h82);
    chk("w_bp_pop2_frac", w_n_frac, 64'h8000000);
    step();
    chk("w_bp_drain_valid", w_out_valid, 0);

    // reset mid-transfer drops held bundles
    w_out_ready = 1'b0;
    w_send(8'h90, 28'h1);
    step();
    w_in_valid = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("w_midrst_count", w_count, 0);
    chk("w_midrst_exp", w_n_exp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
